enigma_seq_ctrl: RTL and testbench
==================================

Name: enigma_seq_ctrl

Overview:
Per-character sequencer for the Enigma datapath.
- Owns the three rotor position registers and applies stepping before each character.
- Time-multiplexes one shared substitution unit (rotor0/1/2 forward, reflector, rotor2/1/0 inverse) across 7 passes per character.
- Sits between the keyboard/UART front end (valid/ready in) and the display/TX path (valid/ready out).

Parameters:
- NOTCH0, 16, rotor0 position ('Q') at which rotor1 is carried.
- NOTCH1, 4, rotor1 position ('E') at which rotor2 is carried.
- NOTCH2, 21, rotor2 notch ('V'); reported only on notch2_hit, no carry.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  load start positions; honoured only in IDLE.
- load_pos0 / load_pos1 / load_pos2  in  6 each  start positions, 0..25 (values >=26 load as value-26).
- in_valid  in  1  plaintext character valid.
- in_ready  out  1  high only in IDLE with load_en low.
- in_char  in  6  letter 0..25.
- lut_sel  out  3  table select: 0=R0, 1=R1, 2=R2, 3=REFL, 4=R2inv, 5=R1inv, 6=R0inv.
- lut_in  out  6  substitution input, 0..25.
- lut_pos  out  6  position applied by the unit, 0..25; 0 for REFL.
- lut_out  in  6  substitution result, combinational in the same cycle.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accept.
- out_char  out  6  ciphertext, 0..25.
- pos0 / pos1 / pos2  out  6 each  current rotor positions.
- busy  out  1  high whenever state != IDLE.
- notch2_hit  out  1  one-cycle pulse when rotor2 steps onto NOTCH2.

Behaviour:
- Reset values: all outputs 0; pos0/1/2 = 0; state = IDLE. Reset mid-character aborts the character; no out_valid follows.
- FSM: IDLE -> STEP -> PASS(k=0..6) -> DONE -> IDLE.
- IDLE:
  - load_en has priority over in_valid; loads positions; in_ready is low that cycle.
  - Handshake in_valid & in_ready latches in_char into cur and moves to STEP.
  - If in_char >= 26: no stepping; cur is passed unchanged to DONE with out_char = in_char.
- STEP (1 cycle): pos0 += 1 mod 26.
  - If old pos0 == NOTCH0: pos1 += 1.
  - If old pos1 == NOTCH1 (see feature): pos1 += 1 and pos2 += 1.
  - pos1 increments at most once per character. All wraps are 25 -> 0.
- PASS k (1 cycle each, 7 cycles):
  - Drive lut_sel = k, lut_in = cur, lut_pos = rotor position for k (REFL uses 0).
  - Update cur = (lut_out + 26 - lut_pos) mod 26, computed in 7 bits, result truncated to 6.
- DONE: out_valid = 1 and out_char = cur, held stable until out_ready.
  - Handshake returns to IDLE; in_ready rises the following cycle.
  - Positions never change outside STEP or a load.
- Latency: input accepted at cycle 0; out_valid first asserted at cycle 9. Maximum throughput is one character per 10 cycles with out_ready tied high.
- in_valid asserted while busy: not accepted; the source must hold it.

Optional Feature:
- ENIGMA_DOUBLE_STEP_EN defined: historical double step. old pos1 == NOTCH1 advances both pos1 and pos2.
- Undefined: pure odometer. pos2 steps only when pos1 wraps via carry, i.e. old pos0 == NOTCH0 and old pos1 == 25.

Decomposition:
- Package enigma_pkg holds:
  - N_LETTERS = 26.
  - lut_sel codes SEL_R0..SEL_R0INV.
  - FSM state enum.
  - mod26 increment function.
- One natural sub-module: enigma_rotor_stepper. Combinational; maps old pos0/1/2 plus notch parameters to next positions and the notch2_hit condition; instantiated in STEP.

Test Plan:
- Load (0,0,0), send 0 with identity lut_out = lut_in + lut_pos -> out_char 0; pos = (1,0,0); out_valid first high at cycle 9.
- Load (16,0,0), send 1 char -> pos (17,1,0).
- Load (16,3,0), send 2 chars -> pos (17,4,0), then (18,5,1) with ENIGMA_DOUBLE_STEP_EN; (18,4,0) without it.
- Load (25,25,25), send 1 char -> pos (0,25,25); send in_char 30 -> out_char 30, positions unchanged.
- Hold out_ready low 5 cycles in DONE -> out_char stable, in_ready low, load_en ignored; pulse rst_n low during PASS3 -> all outputs 0, state IDLE.
- 26 back-to-back chars from (0,0,0) -> pos0 wraps to 0, pos1 = 1 after the char stepping pos0 from 16; notch2_hit never pulses.

Source files
------------

// File: rtl/enigma_seq_ctrl_pkg.sv
// Shared constants, table-select codes, FSM states and mod-26 helpers for the Enigma sequencer.
package enigma_pkg;

  localparam int unsigned N_LETTERS = 26;

  localparam logic [2:0] SEL_R0    = 3'd0;
  localparam logic [2:0] SEL_R1    = 3'd1;
  localparam logic [2:0] SEL_R2    = 3'd2;
  localparam logic [2:0] SEL_REFL  = 3'd3;
  localparam logic [2:0] SEL_R2INV = 3'd4;
  localparam logic [2:0] SEL_R1INV = 3'd5;
  localparam logic [2:0] SEL_R0INV = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_PASS,
    ST_DONE
  } state_t;

  function automatic logic [5:0] inc26(input logic [5:0] v);
    if (v >= 6'(N_LETTERS - 1)) return '0;
    return v + 6'd1;
  endfunction

  // Load values above the alphabet fold down by one alphabet length.
  function automatic logic [5:0] fold26(input logic [5:0] v);
    if (v >= 6'(N_LETTERS)) return v - 6'(N_LETTERS);
    return v;
  endfunction

endpackage

// File: rtl/enigma_seq_ctrl_if.sv
// Character streams: plaintext in (valid/ready) and ciphertext out (valid/ready).
interface enigma_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_char;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_char;

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char
  );

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char
  );
endinterface

// File: rtl/enigma_seq_ctrl_stepper.sv
// Combinational rotor stepping; ENIGMA_DOUBLE_STEP_EN selects historical double step over pure odometer.
module enigma_rotor_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
`ifdef ENIGMA_DOUBLE_STEP_EN
  parameter int unsigned NOTCH1 = 4,
`endif
  parameter int unsigned NOTCH2 = 21
) (
  input  logic [5:0] pos0,
  input  logic [5:0] pos1,
  input  logic [5:0] pos2,
  output logic [5:0] nxt0,
  output logic [5:0] nxt1,
  output logic [5:0] nxt2,
  output logic       hit
);

  logic carry1;
  logic adv1;
  logic adv2;

  always_comb begin
    carry1 = (pos0 == 6'(NOTCH0));
`ifdef ENIGMA_DOUBLE_STEP_EN
    adv2 = (pos1 == 6'(NOTCH1));
    adv1 = carry1 || adv2;
`else
    adv1 = carry1;
    adv2 = carry1 && (pos1 == 6'(N_LETTERS - 1));
`endif
    nxt0 = inc26(pos0);
    nxt1 = adv1 ? inc26(pos1) : pos1;
    nxt2 = adv2 ? inc26(pos2) : pos2;
    hit  = adv2 && (nxt2 == 6'(NOTCH2));
  end

endmodule

// File: rtl/enigma_seq_ctrl.sv
// Per-character Enigma sequencer: steps rotors, then time-multiplexes one substitution unit over 7 passes.
// Build option: ENIGMA_DOUBLE_STEP_EN (historical double step of the middle rotor).
module enigma_seq_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4,
  parameter int unsigned NOTCH2 = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [5:0]         load_pos0,
  input  logic [5:0]         load_pos1,
  input  logic [5:0]         load_pos2,
  enigma_seq_ctrl_if.slave   bus,
  output logic [2:0]         lut_sel,
  output logic [5:0]         lut_in,
  output logic [5:0]         lut_pos,
  input  logic [5:0]         lut_out,
  output logic [5:0]         pos0,
  output logic [5:0]         pos1,
  output logic [5:0]         pos2,
  output logic               busy,
  output logic               notch2_hit
);

  if (NOTCH0 >= N_LETTERS || NOTCH1 >= N_LETTERS || NOTCH2 >= N_LETTERS) begin : g_bad_notch
    $error("enigma_seq_ctrl: notch parameters must be below 26");
  end

  state_t     state, state_nxt;
  logic [2:0] pass, pass_nxt;
  logic [5:0] cur;
  logic [5:0] s0, s1, s2;
  logic       s_hit;
  logic       hit_q;
  logic [6:0] diff;
  logic [5:0] cur_nxt;

  enigma_rotor_stepper #(
    .NOTCH0 (NOTCH0),
`ifdef ENIGMA_DOUBLE_STEP_EN
    .NOTCH1 (NOTCH1),
`endif
    .NOTCH2 (NOTCH2)
  ) u_stepper (
    .pos0 (pos0),
    .pos1 (pos1),
    .pos2 (pos2),
    .nxt0 (s0),
    .nxt1 (s1),
    .nxt2 (s2),
    .hit  (s_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pass  <= '0;
    end else begin
      state <= state_nxt;
      pass  <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pass_nxt      = pass;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_char  = '0;
    lut_sel       = '0;
    lut_in        = '0;
    lut_pos       = '0;
    case (state)
      ST_IDLE: begin
        // in_ready is also gated by rst_n so every output reads 0 while reset is held.
        bus.in_ready = rst_n && !load_en;
        if (!load_en && bus.in_valid)
          state_nxt = (bus.in_char >= 6'(N_LETTERS)) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        state_nxt = ST_PASS;
        pass_nxt  = '0;
      end
      ST_PASS: begin
        lut_sel = pass;
        lut_in  = cur;
        case (pass)
          SEL_R0, SEL_R0INV: lut_pos = pos0;
          SEL_R1, SEL_R1INV: lut_pos = pos1;
          SEL_R2, SEL_R2INV: lut_pos = pos2;
          default:           lut_pos = '0;
        endcase
        if (pass == SEL_R0INV) state_nxt = ST_DONE;
        else                   pass_nxt  = pass + 3'd1;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_char  = cur;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    diff    = {1'b0, lut_out} + 7'd26 - {1'b0, lut_pos};
    cur_nxt = 6'(diff % 7'd26);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      pos0  <= '0;
      pos1  <= '0;
      pos2  <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            pos0 <= fold26(load_pos0);
            pos1 <= fold26(load_pos1);
            pos2 <= fold26(load_pos2);
          end else if (bus.in_valid) begin
            cur <= bus.in_char;
          end
        end
        ST_STEP: begin
          pos0  <= s0;
          pos1  <= s1;
          pos2  <= s2;
          hit_q <= s_hit;
        end
        ST_PASS: cur <= cur_nxt;
        default: ;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign notch2_hit = hit_q;

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Self-checking bench for enigma_seq_ctrl with a random substitution unit and a letter-level reference model.
module tb_enigma_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [5:0] load_pos0 = '0, load_pos1 = '0, load_pos2 = '0;
  logic [2:0] lut_sel;
  logic [5:0] lut_in, lut_pos, lut_out;
  logic [5:0] pos0, pos1, pos2;
  logic       busy, notch2_hit;

  enigma_seq_ctrl_if bus();

  enigma_seq_ctrl #(.NOTCH0(16), .NOTCH1(4), .NOTCH2(21)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_pos0  (load_pos0),
    .load_pos1  (load_pos1),
    .load_pos2  (load_pos2),
    .bus        (bus),
    .lut_sel    (lut_sel),
    .lut_in     (lut_in),
    .lut_pos    (lut_pos),
    .lut_out    (lut_out),
    .pos0       (pos0),
    .pos1       (pos1),
    .pos2       (pos2),
    .busy       (busy),
    .notch2_hit (notch2_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_pos[3];
  int hit_cnt = 0;
  bit ident = 1'b1;
  int perm[7][26];

  // Substitution unit: wiring offset by the rotor position, identity or a random table per pass.
  function automatic int lut_f(input int sel, input int x, input int p, input bit id);
    int idx;
    idx = (x + p) % 26;
    if (id || sel > 6) return idx;
    return (perm[sel][idx] + p) % 26;
  endfunction

  always @* lut_out = 6'(lut_f(int'(lut_sel), int'(lut_in), int'(lut_pos), ident));

  always @(negedge clk) if (notch2_hit === 1'b1) hit_cnt++;

  task automatic model_step(output int exp_hit);
    int o0, o1, o2;
    bit c1, ds, st2;
    o0 = m_pos[0]; o1 = m_pos[1]; o2 = m_pos[2];
    c1 = (o0 == 16);
`ifdef ENIGMA_DOUBLE_STEP_EN
    ds  = (o1 == 4);
    st2 = ds;
`else
    ds  = 1'b0;
    st2 = c1 && (o1 == 25);
`endif
    m_pos[0] = (o0 + 1) % 26;
    if (c1 || ds) m_pos[1] = (o1 + 1) % 26;
    if (st2) m_pos[2] = (o2 + 1) % 26;
    exp_hit = (st2 && m_pos[2] == 21) ? 1 : 0;
  endtask

  function automatic int model_enc(input int ch);
    int c, p, o;
    c = ch;
    for (int k = 0; k < 7; k++) begin
      p = (k == 3) ? 0 : m_pos[(k < 3) ? k : 6 - k];
      o = lut_f(k, c, p, ident);
      c = (o + 26 - p) % 26;
    end
    return c;
  endfunction

  task automatic do_load(input int a, input int b, input int c);
    @(negedge clk);
    load_en = 1'b1;
    load_pos0 = 6'(a); load_pos1 = 6'(b); load_pos2 = 6'(c);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_in_ready: got %0b want 0", bus.in_ready);
    end
    @(negedge clk);
    load_en = 1'b0;
    m_pos[0] = (a >= 26) ? a - 26 : a;
    m_pos[1] = (b >= 26) ? b - 26 : b;
    m_pos[2] = (c >= 26) ? c - 26 : c;
  endtask

  task automatic run_char(input int c);
    int lat, exp_out, exp_hit, h0, exp_lat;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_char  = 6'(c);
    h0 = hit_cnt;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (c < 26) begin
      model_step(exp_hit);
      exp_out = model_enc(c);
      exp_lat = 9;
    end else begin
      exp_hit = 0;
      exp_out = c;
      exp_lat = 1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency char=%0d: got %0d want %0d", c, lat, exp_lat);
    end
    checks++;
    if (bus.out_char !== 6'(exp_out) || busy !== 1'b1) begin
      failures++;
      $display("FAIL out_char in=%0d: got %0d busy=%0b want %0d busy=1", c, bus.out_char, busy, exp_out);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done: got ov=%0b ir=%0b busy=%0b want 0 1 0", bus.out_valid, bus.in_ready, busy);
    end
    checks++;
    if (pos0 !== 6'(m_pos[0]) || pos1 !== 6'(m_pos[1]) || pos2 !== 6'(m_pos[2])) begin
      failures++;
      $display("FAIL positions: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               pos0, pos1, pos2, m_pos[0], m_pos[1], m_pos[2]);
    end
    checks++;
    if (hit_cnt - h0 != exp_hit) begin
      failures++;
      $display("FAIL notch2_hit: got %0d pulses want %0d", hit_cnt - h0, exp_hit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_char !== 6'd0 || busy !== 1'b0 ||
        pos0 !== 6'd0 || pos1 !== 6'd0 || pos2 !== 6'd0 || notch2_hit !== 1'b0 ||
        lut_sel !== 3'd0 || lut_in !== 6'd0 || lut_pos !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ov=%0b ir=%0b oc=%0d busy=%0b pos=(%0d,%0d,%0d) want all 0",
               bus.out_valid, bus.in_ready, bus.out_char, busy, pos0, pos1, pos2);
    end
    rst_n = 1'b1;
    m_pos = '{0, 0, 0};
  endtask

  task automatic test_directed();
    ident = 1'b1;
    do_load(0, 0, 0);
    run_char(0);
    do_load(16, 0, 0);
    run_char(5);
    checks++;
    if (pos0 !== 6'd17 || pos1 !== 6'd1 || pos2 !== 6'd0) begin
      failures++;
      $display("FAIL carry1: got (%0d,%0d,%0d) want (17,1,0)", pos0, pos1, pos2);
    end
    do_load(16, 3, 0);
    run_char(7);
    run_char(8);
    checks++;
`ifdef ENIGMA_DOUBLE_STEP_EN
    if (pos0 !== 6'd18 || pos1 !== 6'd5 || pos2 !== 6'd1) begin
      failures++;
      $display("FAIL double_step: got (%0d,%0d,%0d) want (18,5,1)", pos0, pos1, pos2);
    end
`else
    if (pos0 !== 6'd18 || pos1 !== 6'd4 || pos2 !== 6'd0) begin
      failures++;
      $display("FAIL odometer: got (%0d,%0d,%0d) want (18,4,0)", pos0, pos1, pos2);
    end
`endif
    do_load(25, 25, 25);
    run_char(3);
    checks++;
    if (pos0 !== 6'd0 || pos1 !== 6'd25 || pos2 !== 6'd25) begin
      failures++;
      $display("FAIL wrap: got (%0d,%0d,%0d) want (0,25,25)", pos0, pos1, pos2);
    end
    run_char(30);
    do_load(42, 27, 63);
    run_char(1);
  endtask

  task automatic test_notch2();
    ident = 1'b0;
    do_load(16, 25, 20);
    run_char(11);
    do_load(0, 4, 20);
    run_char(12);
  endtask

  task automatic test_backpressure();
    int c, exp_out, dummy, n;
    ident = 1'b0;
    do_load($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
    c = $urandom_range(0, 25);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_char   = 6'(c);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model_step(dummy);
    exp_out = model_enc(c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_char !== 6'(exp_out) || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_done cyc=%0d: got ov=%0b oc=%0d ir=%0b want 1 %0d 0",
                 i, bus.out_valid, bus.out_char, bus.in_ready, exp_out);
      end
      load_en = 1'b1;
      load_pos0 = 6'($urandom_range(0, 25));
      load_pos1 = 6'($urandom_range(0, 25));
      load_pos2 = 6'($urandom_range(0, 25));
      @(negedge clk);
    end
    load_en = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || pos0 !== 6'(m_pos[0]) || pos1 !== 6'(m_pos[1]) || pos2 !== 6'(m_pos[2])) begin
      failures++;
      $display("FAIL load_ignored: got ov=%0b pos=(%0d,%0d,%0d) want 0 (%0d,%0d,%0d)",
               bus.out_valid, pos0, pos1, pos2, m_pos[0], m_pos[1], m_pos[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    do_load(5, 6, 7);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = 6'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lut_sel !== 3'd3 && n < 20);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0 || lut_sel !== 3'd0 ||
        lut_pos !== 6'd0 || lut_in !== 6'd0 || pos0 !== 6'd0 || pos1 !== 6'd0 || pos2 !== 6'd0) begin
      failures++;
      $display("FAIL reset_mid: got ov=%0b ir=%0b busy=%0b sel=%0d pos=(%0d,%0d,%0d) want all 0",
               bus.out_valid, bus.in_ready, busy, lut_sel, pos0, pos1, pos2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pos = '{0, 0, 0};
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_output: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    ident = 1'b0;
    do_load(0, 0, 0);
    for (int i = 0; i < 26; i++) run_char($urandom_range(0, 25));
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0)
        do_load($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) run_char($urandom_range(26, 63));
      else                           run_char($urandom_range(0, 25));
    end
  endtask

  initial begin
    int j, t;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 26; i++) perm[s][i] = i;
      for (int i = 25; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = perm[s][i]; perm[s][i] = perm[s][j]; perm[s][j] = t;
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_notch2();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
